dbus_ram: RTL

DBUS_RAM -- requirements
Module: dbus_ram

---
 rtl/dbus_ram.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dbus_ram.sv
// dbus_ram: single-port word RAM behind a simple request/ack data bus.
// Each accepted access takes WAIT_STATES+1 cycles to complete.
// Optional macro DBUS_RAM_ERR_EN: out-of-range addresses are flagged on
// o_mem_err, their writes are dropped and their reads return zero.
// Without it, upper address bits are ignored and o_mem_err stays 0.
module dbus_ram #(
    parameter int DATA_DBUS_WIDTH = 32,
    parameter int ADDR_DBUS_WIDTH = 32,
    parameter int RAM_WORDS       = 1024,
    parameter int WAIT_STATES     = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_mem_req,
    input  logic                       i_mem_we,
    input  logic [3:0]                 i_mem_be,
    input  logic [ADDR_DBUS_WIDTH-1:0] i_mem_addr,
    input  logic [DATA_DBUS_WIDTH-1:0] i_mem_wr_data,
    output logic                       o_mem_ready,
    output logic                       o_mem_ack,
    output logic [DATA_DBUS_WIDTH-1:0] o_mem_rd_data,
    output logic                       o_mem_err
);

    localparam int         IDX_W = $clog2(RAM_WORDS);
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                     state_q;
    logic [3:0]                 cnt_q;
    logic                       ready_q;
    logic                       ack_q;
    logic                       err_q;
    logic [DATA_DBUS_WIDTH-1:0] rd_data_q;

    // Request captured at acceptance, used when the access completes later
    logic                       lat_we_q;
    logic [3:0]                 lat_be_q;
    logic [ADDR_DBUS_WIDTH-1:0] lat_addr_q;
    logic [DATA_DBUS_WIDTH-1:0] lat_data_q;

    // The access that commits on the coming edge
    logic                       acc_we;
    logic [3:0]                 acc_be;
    logic [ADDR_DBUS_WIDTH-1:0] acc_addr;
    logic [DATA_DBUS_WIDTH-1:0] acc_wdata;
    logic [IDX_W-1:0]           acc_idx;
    logic                       acc_oob;

    logic accept;
    logic wait_done;
    logic commit;

    logic [DATA_DBUS_WIDTH-1:0] mem [RAM_WORDS];

    assign accept    = i_mem_req & ready_q;
    assign wait_done = (state_q == WAIT) && (cnt_q == 4'd1);

    // With no wait states the access completes on its own acceptance edge,
    // so it must use the live bus; otherwise it uses the latched copy.
    generate
        if (WAIT_STATES == 0) begin : g_direct
            assign acc_we    = i_mem_we;
            assign acc_be    = i_mem_be;
            assign acc_addr  = i_mem_addr;
            assign acc_wdata = i_mem_wr_data;
            assign commit    = i_rst & accept;
        end else begin : g_latched
            assign acc_we    = lat_we_q;
            assign acc_be    = lat_be_q;
            assign acc_addr  = lat_addr_q;
            assign acc_wdata = lat_data_q;
            assign commit    = i_rst & wait_done;
        end
    endgenerate

    assign acc_idx = acc_addr[IDX_W+1:2];

`ifdef DBUS_RAM_ERR_EN
    localparam logic [ADDR_DBUS_WIDTH:0] RANGE_BYTES = (ADDR_DBUS_WIDTH+1)'(RAM_WORDS * 4);
    assign acc_oob = ({1'b0, acc_addr} >= RANGE_BYTES);
`else
    assign acc_oob = 1'b0;
`endif

    // Byte-offset and (when unchecked) upper address bits carry no meaning
    logic unused_bits;
    assign unused_bits = ^{acc_addr, lat_we_q, lat_be_q, lat_addr_q, lat_data_q};

    // Capture the request on acceptance
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lat_we_q   <= i_mem_we;
            lat_be_q   <= i_mem_be;
            lat_addr_q <= i_mem_addr;
            lat_data_q <= i_mem_wr_data;
        end
    end

    // Control FSM: IDLE -> (WAIT) -> RESP, with back-to-back acceptance in RESP
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b1;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (accept) begin
                if (WS == 4'd0) begin
                    state_q <= RESP;
                    ready_q <= 1'b1;
                    ack_q   <= 1'b1;
                    err_q   <= acc_oob;
                end else begin
                    state_q <= WAIT;
                    cnt_q   <= WS;
                    ready_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    WAIT: begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                            ack_q   <= 1'b1;
                            err_q   <= acc_oob;
                        end
                    end
                    RESP:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Byte-lane write into the array on the edge that enters RESP
    always_ff @(posedge i_clk) begin
        if (commit && acc_we && !acc_oob) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered read port; holds its value across write acks
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rd_data_q <= '0;
        end else if (commit && !acc_we) begin
            rd_data_q <= acc_oob ? '0 : mem[acc_idx];
        end
    end

    assign o_mem_ready   = ready_q;
    assign o_mem_ack     = ack_q;
    assign o_mem_err     = err_q;
    assign o_mem_rd_data = rd_data_q;

endmodule
